// File: rtl/dsp48a1_mac_seq_if.sv
// Term-stream and result-stream handshakes between a producer/consumer and the
// DSP48A1 MAC issue sequencer.
interface dsp48a1_mac_seq_if;
    logic        in_valid;
    logic        in_ready;
    logic [17:0] in_a;
    logic [17:0] in_b;
    logic [17:0] in_d;
    logic [47:0] in_c;
    logic        in_last;
    logic        res_valid;
    logic        res_ready;
    logic [47:0] res_data;
    logic        res_carry;

    modport master (
        output in_valid, in_a, in_b, in_d, in_c, in_last, res_ready,
        input  in_ready, res_valid, res_data, res_carry
    );

    modport slave (
        input  in_valid, in_a, in_b, in_d, in_c, in_last, res_ready,
        output in_ready, res_valid, res_data, res_carry
    );
endinterface

// File: rtl/dsp48a1_mac_seq.sv
// Issue-side sequencer for a DSP48A1 slice: streams (D+B)*A terms, adds a packet
// bias, tracks slice latency and buffers packet sums in a 2-entry result FIFO.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// ST_FIRST | next accepted beat starts a packet (Z=C, bias loaded)
// ST_MID   | inside a packet; next accepted beat accumulates onto P (Z=P)
module dsp48a1_mac_seq #(
    parameter int LAT       = 4,
    parameter int ALIGN_DLY = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    dsp48a1_mac_seq_if.slave        bus,
    output logic [17:0]             dsp_a,
    output logic [17:0]             dsp_b,
    output logic [17:0]             dsp_d,
    output logic [47:0]             dsp_c,
    output logic [7:0]              dsp_opmode,
    output logic                    dsp_carryin,
    output logic                    dsp_ce,
    output logic                    dsp_rst,
    input  logic [47:0]             dsp_p,
    input  logic                    dsp_carryout,
    output logic                    busy
);

    localparam logic [7:0] OPM_FIRST = 8'h1D;
    localparam logic [7:0] OPM_MID   = 8'h19;
    localparam logic [7:0] OPM_HOLD  = 8'h08;

    typedef enum logic {ST_FIRST, ST_MID} pkt_state_t;

    pkt_state_t  state, state_nxt;
    logic        dsp_rst_q;
    logic        accept;
    logic [7:0]  opm_in;
    logic [47:0] c_in;
    logic [7:0]  opm_dly [ALIGN_DLY];
    logic [47:0] c_dly   [ALIGN_DLY];
    logic [LAT-1:0] term_tag;
    logic [LAT-1:0] last_tag;
    logic [7:0]  credit_use;
    logic        push;
    logic        pop;
    logic [48:0] fifo_mem [2];
    logic        wr_ptr;
    logic        rd_ptr;
    logic [1:0]  fifo_count;

    // Slice reset is held one edge past rst_n release so the slice sees a clean sync reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) dsp_rst_q <= 1'b1;
        else        dsp_rst_q <= 1'b0;
    end

    assign dsp_rst     = dsp_rst_q;
    assign dsp_ce      = ~dsp_rst_q;
    assign dsp_carryin = 1'b0;
    assign dsp_a       = bus.in_a;
    assign dsp_b       = bus.in_b;
    assign dsp_d       = bus.in_d;

    assign accept = bus.in_valid & bus.in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_FIRST;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        opm_in    = OPM_HOLD;
        c_in      = '0;
        if (accept) begin
            case (state)
                ST_FIRST: begin
                    opm_in = OPM_FIRST;
                    c_in   = bus.in_c;
                    if (!bus.in_last) state_nxt = ST_MID;
                end
                ST_MID: begin
                    opm_in = OPM_MID;
                    if (bus.in_last) state_nxt = ST_FIRST;
                end
                default: state_nxt = ST_FIRST;
            endcase
        end
    end

    // OPMODE/C trail the operands so the slice's OPMODEREG/CREG line up with MREG.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ALIGN_DLY; i++) begin
                opm_dly[i] <= OPM_HOLD;
                c_dly[i]   <= '0;
            end
        end else begin
            opm_dly[0] <= opm_in;
            c_dly[0]   <= c_in;
            for (int i = 1; i < ALIGN_DLY; i++) begin
                opm_dly[i] <= opm_dly[i-1];
                c_dly[i]   <= c_dly[i-1];
            end
        end
    end

    assign dsp_opmode = opm_dly[ALIGN_DLY-1];
    assign dsp_c      = c_dly[ALIGN_DLY-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            term_tag <= '0;
            last_tag <= '0;
        end else begin
            term_tag <= {term_tag[LAT-2:0], accept};
            last_tag <= {last_tag[LAT-2:0], accept & bus.in_last};
        end
    end

    // A packet reserves its FIFO slot when its last beat is accepted.
    always_comb begin
        credit_use = {6'd0, fifo_count};
        for (int i = 0; i < LAT; i++) begin
            credit_use = credit_use + {7'd0, last_tag[i]};
        end
    end

    assign bus.in_ready = ~dsp_rst_q & (credit_use < 8'd2);

    assign push = last_tag[LAT-1];
    assign pop  = bus.res_valid & bus.res_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fifo_mem[0] <= '0;
            fifo_mem[1] <= '0;
            wr_ptr      <= 1'b0;
            rd_ptr      <= 1'b0;
            fifo_count  <= 2'd0;
        end else begin
            if (push) begin
                fifo_mem[wr_ptr] <= {dsp_carryout, dsp_p};
                wr_ptr           <= ~wr_ptr;
            end
            if (pop) rd_ptr <= ~rd_ptr;
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 2'd1;
                2'b01:   fifo_count <= fifo_count - 2'd1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    assign bus.res_valid = (fifo_count != 2'd0);
    assign bus.res_data  = fifo_mem[rd_ptr][47:0];
    assign bus.res_carry = fifo_mem[rd_ptr][48];

    assign busy = (|term_tag) | (fifo_count != 2'd0);

endmodule

// File: tb/tb_dsp48a1_mac_seq.sv
// Directed bench for dsp48a1_mac_seq with a behavioural DSP48A1 slice model
// (operand regs, pre-add reg, MREG, OPMODEREG/CREG, PREG).
module tb_dsp48a1_mac_seq;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    dsp48a1_mac_seq_if bus();

    logic [17:0] dsp_a, dsp_b, dsp_d;
    logic [47:0] dsp_c, dsp_p;
    logic [7:0]  dsp_opmode;
    logic        dsp_carryin, dsp_ce, dsp_rst, dsp_carryout, busy;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    dsp48a1_mac_seq dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .bus          (bus),
        .dsp_a        (dsp_a),
        .dsp_b        (dsp_b),
        .dsp_d        (dsp_d),
        .dsp_c        (dsp_c),
        .dsp_opmode   (dsp_opmode),
        .dsp_carryin  (dsp_carryin),
        .dsp_ce       (dsp_ce),
        .dsp_rst      (dsp_rst),
        .dsp_p        (dsp_p),
        .dsp_carryout (dsp_carryout),
        .busy         (busy)
    );

    always @(posedge clk) cyc <= cyc + 1;

    // Slice model: operands at k, pre-add at k+1, MREG/OPMODEREG/CREG at k+2, PREG at k+3.
    logic [17:0] s1_a, s1_b, s1_d, s2_a, s2_pa;
    logic [35:0] m_r;
    logic [7:0]  op_r;
    logic [47:0] c_r, x_mux, z_mux;

    always_comb begin
        x_mux = (op_r[1:0] == 2'b01) ? {12'd0, m_r} : 48'd0;
        case (op_r[3:2])
            2'b10:   z_mux = dsp_p;
            2'b11:   z_mux = c_r;
            default: z_mux = 48'd0;
        endcase
    end

    always @(posedge clk) begin
        if (dsp_rst) begin
            s1_a <= '0; s1_b <= '0; s1_d <= '0; s2_a <= '0; s2_pa <= '0;
            m_r <= '0; op_r <= '0; c_r <= '0; dsp_p <= '0; dsp_carryout <= 1'b0;
        end else if (dsp_ce) begin
            s1_a  <= dsp_a;
            s1_b  <= dsp_b;
            s1_d  <= dsp_d;
            s2_a  <= s1_a;
            s2_pa <= s1_d + s1_b;
            m_r   <= 36'(s2_a) * 36'(s2_pa);
            op_r  <= dsp_opmode;
            c_r   <= dsp_c;
            {dsp_carryout, dsp_p} <= {1'b0, z_mux} + {1'b0, x_mux} + {48'd0, dsp_carryin};
        end
    end

    task automatic beat(input logic [17:0] a, input logic [17:0] b, input logic [17:0] d,
                        input logic [47:0] c, input logic last, output int acc);
        logic ok;
        int n;
        n = 0;
        ok = 1'b0;
        acc = -1;
        bus.in_valid = 1'b1;
        bus.in_a = a; bus.in_b = b; bus.in_d = d; bus.in_c = c; bus.in_last = last;
        while (!ok && n < 50) begin
            ok = bus.in_ready;
            acc = cyc;
            @(negedge clk);
            n++;
        end
        bus.in_valid = 1'b0;
        if (!ok) begin
            checks++;
            failures++;
            $display("FAIL beat_accept: in_ready never high, required accept within 50 cycles");
        end
    endtask

    task automatic pop_result(input string name, input logic [47:0] exp_data, input logic exp_carry);
        int n;
        n = 0;
        while (!bus.res_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (bus.res_valid !== 1'b1) begin
            failures++;
            $display("FAIL %s_valid: res_valid=%b required 1 within 20 cycles", name, bus.res_valid);
        end else begin
            checks++;
            if (bus.res_data !== exp_data) begin
                failures++;
                $display("FAIL %s_data: got %0d required %0d", name, bus.res_data, exp_data);
            end
            checks++;
            if (bus.res_carry !== exp_carry) begin
                failures++;
                $display("FAIL %s_carry: got %b required %b", name, bus.res_carry, exp_carry);
            end
            bus.res_ready = 1'b1;
            @(negedge clk);
            bus.res_ready = 1'b0;
        end
    endtask

    task automatic check_reset_outputs(input string name);
        checks++;
        if (bus.in_ready !== 1'b0 || bus.res_valid !== 1'b0 || bus.res_data !== 48'd0 ||
            bus.res_carry !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL %s_outs: in_ready=%b res_valid=%b res_data=%0d res_carry=%b busy=%b required all 0",
                     name, bus.in_ready, bus.res_valid, bus.res_data, bus.res_carry, busy);
        end
        checks++;
        if (dsp_ce !== 1'b0 || dsp_rst !== 1'b1 || dsp_opmode !== 8'h08 || dsp_c !== 48'd0) begin
            failures++;
            $display("FAIL %s_dsp: ce=%b rst=%b opmode=%h c=%0d required ce=0 rst=1 opmode=08 c=0",
                     name, dsp_ce, dsp_rst, dsp_opmode, dsp_c);
        end
    endtask

    task automatic test_reset();
        check_reset_outputs("reset");
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (dsp_rst !== 1'b0 || dsp_ce !== 1'b1 || bus.in_ready !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL release: rst=%b ce=%b in_ready=%b busy=%b required 0 1 1 0",
                     dsp_rst, dsp_ce, bus.in_ready, busy);
        end
    endtask

    task automatic test_single();
        int acc;
        beat(18'd3, 18'd2, 18'd5, 48'd10, 1'b1, acc);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (bus.res_valid !== 1'b0) begin
                failures++;
                $display("FAIL single_latency: res_valid=%b at cycle %0d after accept, required 0", bus.res_valid, i);
            end
            if (i == 1) begin
                checks++;
                if (dsp_opmode !== 8'h1D || dsp_c !== 48'd10) begin
                    failures++;
                    $display("FAIL single_align: opmode=%h c=%0d required 1d and 10", dsp_opmode, dsp_c);
                end
            end
            @(negedge clk);
        end
        checks++;
        if (bus.res_valid !== 1'b1) begin
            failures++;
            $display("FAIL single_valid_at_lat: res_valid=%b required 1", bus.res_valid);
        end
        pop_result("single", 48'd31, 1'b0);
    endtask

    task automatic test_multi();
        int acc;
        beat(18'd1, 18'd1, 18'd1, 48'd100, 1'b0, acc);
        beat(18'd2, 18'd0, 18'd3, 48'd0, 1'b0, acc);
        beat(18'd4, 18'd2, 18'd2, 48'd0, 1'b1, acc);
        pop_result("multi", 48'd124, 1'b0);
    endtask

    task automatic test_bubble();
        int acc;
        beat(18'd1, 18'd1, 18'd1, 48'd100, 1'b0, acc);
        @(negedge clk);
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL bubble_busy: busy=%b required 1", busy);
        end
        beat(18'd2, 18'd0, 18'd3, 48'd777, 1'b0, acc);
        beat(18'd4, 18'd2, 18'd2, 48'd555, 1'b1, acc);
        pop_result("bubble", 48'd124, 1'b0);
    endtask

    task automatic test_back_to_back();
        int acc1, acc2, acc3;
        beat(18'd3, 18'd2, 18'd5, 48'd10, 1'b1, acc1);
        beat(18'd1, 18'd1, 18'd1, 48'd5, 1'b1, acc2);
        checks++;
        if (acc2 !== acc1 + 1) begin
            failures++;
            $display("FAIL b2b_gap: second accept at %0d required %0d", acc2, acc1 + 1);
        end
        checks++;
        if (bus.in_ready !== 1'b0) begin
            failures++;
            $display("FAIL b2b_credit: in_ready=%b required 0 after two lasts", bus.in_ready);
        end
        repeat (6) @(negedge clk);
        checks++;
        if (bus.in_ready !== 1'b0 || bus.res_valid !== 1'b1) begin
            failures++;
            $display("FAIL b2b_full: in_ready=%b res_valid=%b required 0 1", bus.in_ready, bus.res_valid);
        end
        pop_result("b2b_first", 48'd31, 1'b0);
        beat(18'd2, 18'd3, 18'd4, 48'd0, 1'b1, acc3);
        pop_result("b2b_second", 48'd7, 1'b0);
        pop_result("b2b_third", 48'd14, 1'b0);
        repeat (2) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || bus.res_valid !== 1'b0) begin
            failures++;
            $display("FAIL b2b_idle: busy=%b res_valid=%b required 0 0", busy, bus.res_valid);
        end
    endtask

    task automatic test_reset_mid();
        int acc;
        beat(18'd1, 18'd1, 18'd1, 48'd100, 1'b0, acc);
        beat(18'd2, 18'd0, 18'd3, 48'd0, 1'b0, acc);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("mid_reset");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        beat(18'd2, 18'd1, 18'd1, 48'd0, 1'b1, acc);
        pop_result("after_reset", 48'd4, 1'b0);
    endtask

    task automatic test_wrap();
        int acc;
        beat(18'd1, 18'd0, 18'd1, 48'hFFFF_FFFF_FFFF, 1'b1, acc);
        pop_result("wrap", 48'd0, 1'b1);
        repeat (2) @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL final_busy: busy=%b required 0", busy);
        end
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.in_a = '0; bus.in_b = '0; bus.in_d = '0; bus.in_c = '0; bus.in_last = 1'b0;
        bus.res_ready = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        test_reset();
        test_single();
        test_multi();
        test_bubble();
        test_back_to_back();
        test_reset_mid();
        test_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
